square_wave_i2s_tx: RTL and testbench

//  Consumer end of the note half-period bus: takes halfPeriodTotal (sample-tick units, 0 = silence),

---
 rtl/synth_pkg.sv | 13 +
 rtl/i2s_clock_gen.sv | 48 ++++
 rtl/square_wave_i2s_tx.sv | 110 +++++++++++
 tb/tb_square_wave_i2s_tx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants for the note synthesiser audio path.
package synth_pkg;

  localparam int HALF_PERIOD_W  = 10;
  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FRAME_BITS = 64;
  localparam int SAMPLE_RATE_HZ = 48000;
  localparam int BCLK_HZ        = 3_072_000;

  localparam int BIT_CNT_W = $clog2(I2S_FRAME_BITS);
  localparam int SLOT_POS_W = $clog2(I2S_SLOT_BITS);

endpackage

// File: rtl/i2s_clock_gen.sv
// I2S bit clock generator: divides clk down to BCLK and tracks the 64-slot frame position.
module i2s_clock_gen
  import synth_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 bclk,
  output logic [BIT_CNT_W-1:0] bit_cnt_next,
  output logic                 fall_stb,
  output logic                 frame_stb
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 bclk_q, bclk_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 div_wrap;

  // Divider wrap toggles bclk; a wrap while bclk is high is the falling edge that advances the slot.
  always_comb begin
    div_wrap     = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    div_cnt_d    = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d       = div_wrap ? ~bclk_q : bclk_q;
    fall_stb     = div_wrap && bclk_q;
    frame_stb    = fall_stb && (bit_cnt_q == BIT_CNT_W'(I2S_FRAME_BITS - 1));
    bit_cnt_next = bit_cnt_q + BIT_CNT_W'(1);
    bit_cnt_d    = fall_stb ? bit_cnt_next : bit_cnt_q;
  end

  // Divider, bit clock and slot counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bclk = bclk_q;

endmodule

// File: rtl/square_wave_i2s_tx.sv
// Square-wave oscillator stepped once per 48 kHz frame, serialised as I2S (same word on L and R).
module square_wave_i2s_tx
  import synth_pkg::*;
#(
  parameter int                    CLK_DIV   = 1,
  parameter int                    SAMPLE_W  = 16,
  parameter logic [SAMPLE_W-1:0]   AMPLITUDE = 16'h4000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [HALF_PERIOD_W-1:0] halfPeriodTotal,
  output logic                     bclk,
  output logic                     lrclk,
  output logic                     sdata,
  output logic                     sample_tick
);

  localparam logic [SAMPLE_W-1:0] AMP_NEG = -AMPLITUDE;

  logic [BIT_CNT_W-1:0] bit_cnt_next;
  logic                 fall_stb;
  logic                 frame_stb;

  i2s_clock_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clock_gen (
    .clk          (clk),
    .rst          (rst),
    .bclk         (bclk),
    .bit_cnt_next (bit_cnt_next),
    .fall_stb     (fall_stb),
    .frame_stb    (frame_stb)
  );

  logic [HALF_PERIOD_W-1:0] hp_q, hp_d;
  logic [HALF_PERIOD_W-1:0] phase_q, phase_d;
  logic [HALF_PERIOD_W:0]   phase_inc;
  logic                     level_q, level_d;
  logic [SAMPLE_W-1:0]      sample_q, sample_d;
  logic                     lrclk_q, lrclk_d;
  logic                     sdata_q, sdata_d;
  logic                     sample_tick_q, sample_tick_d;
  logic [SLOT_POS_W-1:0]    slot_pos;

  // Oscillator step at frame start; the >= compare lets a shrunk half-period toggle immediately.
  always_comb begin
    hp_d          = hp_q;
    phase_d       = phase_q;
    level_d       = level_q;
    sample_d      = sample_q;
    sample_tick_d = frame_stb;
    phase_inc     = {1'b0, phase_q} + (HALF_PERIOD_W + 1)'(1);
    if (frame_stb) begin
      hp_d = halfPeriodTotal;
      if (hp_d == '0) begin
        phase_d  = '0;
        level_d  = 1'b1;
        sample_d = '0;
      end else begin
        if (phase_inc >= {1'b0, hp_d}) begin
          phase_d = '0;
          level_d = ~level_q;
        end else begin
          phase_d = phase_inc[HALF_PERIOD_W-1:0];
        end
        sample_d = level_d ? AMPLITUDE : AMP_NEG;
      end
    end
  end

  // Slot mux: one-bit I2S delay puts the MSB in slot 1 of each half-frame; slot 0 and pads are zero.
  always_comb begin
    lrclk_d  = lrclk_q;
    sdata_d  = sdata_q;
    slot_pos = bit_cnt_next[SLOT_POS_W-1:0];
    if (fall_stb) begin
      lrclk_d = bit_cnt_next[BIT_CNT_W-1];
      sdata_d = 1'b0;
      for (int i = 0; i < SAMPLE_W; i++) begin
        if (slot_pos == SLOT_POS_W'(SAMPLE_W - i)) sdata_d = sample_q[i];
      end
    end
  end

  // Oscillator and serial output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_q          <= '0;
      phase_q       <= '0;
      level_q       <= 1'b1;
      sample_q      <= '0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      sample_tick_q <= 1'b0;
    end else begin
      hp_q          <= hp_d;
      phase_q       <= phase_d;
      level_q       <= level_d;
      sample_q      <= sample_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      sample_tick_q <= sample_tick_d;
    end
  end

  assign lrclk       = lrclk_q;
  assign sdata       = sdata_q;
  assign sample_tick = sample_tick_q;

endmodule

// File: tb/tb_square_wave_i2s_tx.sv
// Bench for square_wave_i2s_tx with CLK_DIV=1, SAMPLE_W=16, AMPLITUDE=16'h4000.
module tb_square_wave_i2s_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hp  = '0;
  logic       bclk, lrclk, sdata, sample_tick;

  always #5 clk = ~clk;

  square_wave_i2s_tx #(
    .CLK_DIV   (1),
    .SAMPLE_W  (16),
    .AMPLITUDE (16'h4000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .halfPeriodTotal (hp),
    .bclk            (bclk),
    .lrclk           (lrclk),
    .sdata           (sdata),
    .sample_tick     (sample_tick)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: clk edges since release, frames ticked, oscillator phase/level and current word.
  int          m_n;
  int          m_ticks;
  int          m_phase;
  logic        m_level;
  logic [15:0] m_word;
  logic [15:0] cap_l, cap_r;

  function automatic void model_reset();
    m_n = 0; m_ticks = 0; m_phase = 0; m_level = 1'b1; m_word = '0;
  endfunction

  // One clk edge: every 128 edges (64 bclk periods) a new frame computes the next sample.
  function automatic void model_edge(input int hp_now);
    m_n++;
    if (m_n % 128 == 0) begin
      m_ticks++;
      if (hp_now == 0) begin
        m_phase = 0; m_level = 1'b1; m_word = '0;
      end else begin
        if (m_phase + 1 >= hp_now) begin
          m_phase = 0; m_level = !m_level;
        end else begin
          m_phase++;
        end
        m_word = m_level ? 16'h4000 : 16'hC000;
      end
    end
  endfunction

  // Expected {bclk, lrclk, sdata, sample_tick} after m_n edges.
  function automatic logic [3:0] exp_outs();
    int slot, pos;
    logic [15:0] sh;
    logic b, l, d, t;
    b = (m_n % 2 == 1);
    slot = (m_n / 2) % 64;
    pos = slot % 32;
    l = (slot >= 32);
    d = 1'b0;
    if (pos >= 1 && pos <= 16) begin
      sh = m_word >> (16 - pos);
      d = sh[0];
    end
    t = (m_n > 0) && (m_n % 128 == 0);
    return {b, l, d, t};
  endfunction

  function automatic logic at_slot(input int s);
    return (m_n % 2 == 0) && ((m_n / 2) % 64 == s);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge(int'(hp));
    @(negedge clk);
  endtask

  task automatic capture_bit();
    int slot, pos;
    if (m_n % 2 == 0) begin
      slot = (m_n / 2) % 64;
      pos = slot % 32;
      if (pos >= 1 && pos <= 16) begin
        if (slot < 32) cap_l = {cap_l[14:0], sdata};
        else           cap_r = {cap_r[14:0], sdata};
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hp = '0;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({bclk, lrclk, sdata, sample_tick} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold got %b exp 0000", {bclk, lrclk, sdata, sample_tick});
      end
    end
    rst = 1'b0;
    model_reset();
    for (int c = 1; c <= 8; c++) begin
      step();
      n_tests++;
      if (bclk !== logic'(c % 2)) begin
        n_fail++;
        $display("FAIL reset_bclk cyc %0d got %b exp %b", c, bclk, logic'(c % 2));
      end
      n_tests++;
      if ({bclk, lrclk, sdata, sample_tick} !== exp_outs()) begin
        n_fail++;
        $display("FAIL reset_outs cyc %0d got %b exp %b", c, {bclk, lrclk, sdata, sample_tick}, exp_outs());
      end
    end
  endtask

  task automatic test_silence();
    int ticks = 0;
    hp = '0;
    do_reset();
    for (int c = 0; c < 4 * 128 + 2; c++) begin
      step();
      if (sample_tick === 1'b1) ticks++;
      n_tests++;
      if ({bclk, lrclk, sdata, sample_tick} !== exp_outs()) begin
        n_fail++;
        $display("FAIL silence n %0d got %b exp %b", m_n, {bclk, lrclk, sdata, sample_tick}, exp_outs());
      end
    end
    n_tests++;
    if (ticks != 4) begin
      n_fail++;
      $display("FAIL silence_ticks got %0d exp 4", ticks);
    end
  endtask

  task automatic test_square55();
    logic [15:0] exp_w;
    hp = 10'd55;
    do_reset();
    for (int c = 0; c < 112 * 128 + 100; c++) begin
      step();
      capture_bit();
      n_tests++;
      if ({bclk, lrclk, sdata, sample_tick} !== exp_outs()) begin
        n_fail++;
        $display("FAIL sq55 n %0d got %b exp %b", m_n, {bclk, lrclk, sdata, sample_tick}, exp_outs());
      end
      if (at_slot(48)) begin
        if (m_ticks == 0)       exp_w = 16'h0000;
        else if (m_ticks <= 54) exp_w = 16'h4000;
        else if (m_ticks <= 109) exp_w = 16'hC000;
        else                    exp_w = 16'h4000;
        n_tests++;
        if (cap_l !== exp_w || cap_r !== exp_w) begin
          n_fail++;
          $display("FAIL sq55_word frame %0d got L=%h R=%h exp %h", m_ticks, cap_l, cap_r, exp_w);
        end
      end
    end
  endtask

  task automatic test_shrink();
    logic [15:0] exp_w;
    hp = 10'd92;
    do_reset();
    for (int c = 0; c < 20000 && m_ticks < 60; c++) begin
      step();
      n_tests++;
      if ({bclk, lrclk, sdata, sample_tick} !== exp_outs()) begin
        n_fail++;
        $display("FAIL shrink_pre n %0d got %b exp %b", m_n, {bclk, lrclk, sdata, sample_tick}, exp_outs());
      end
    end
    n_tests++;
    if (m_ticks != 60) begin
      n_fail++;
      $display("FAIL shrink_reach got %0d ticks exp 60", m_ticks);
    end
    hp = 10'd49;
    for (int c = 0; c < 100 * 128 + 60; c++) begin
      step();
      capture_bit();
      n_tests++;
      if ({bclk, lrclk, sdata, sample_tick} !== exp_outs()) begin
        n_fail++;
        $display("FAIL shrink n %0d got %b exp %b", m_n, {bclk, lrclk, sdata, sample_tick}, exp_outs());
      end
      if (at_slot(48)) begin
        if (m_ticks <= 60) exp_w = 16'h4000;
        else exp_w = (((m_ticks - 61) / 49) % 2 == 0) ? 16'hC000 : 16'h4000;
        n_tests++;
        if (cap_l !== exp_w || cap_r !== exp_w) begin
          n_fail++;
          $display("FAIL shrink_word frame %0d got L=%h R=%h exp %h", m_ticks, cap_l, cap_r, exp_w);
        end
      end
    end
  endtask

  task automatic test_random();
    hp = 10'($urandom_range(1, 7));
    do_reset();
    for (int c = 0; c < 40 * 128; c++) begin
      if ($urandom_range(0, 199) == 0) hp = 10'($urandom_range(0, 7));
      step();
      capture_bit();
      n_tests++;
      if ({bclk, lrclk, sdata, sample_tick} !== exp_outs()) begin
        n_fail++;
        $display("FAIL random n %0d hp %0d got %b exp %b", m_n, hp, {bclk, lrclk, sdata, sample_tick}, exp_outs());
      end
      if (at_slot(48)) begin
        n_tests++;
        if (cap_l !== cap_r) begin
          n_fail++;
          $display("FAIL random_lr frame %0d got L=%h R=%h", m_ticks, cap_l, cap_r);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_w;
    hp = 10'd3;
    do_reset();
    for (int c = 0; c < 2000 && !(m_ticks == 5 && at_slot(40)); c++) step();
    n_tests++;
    if (!(m_ticks == 5 && at_slot(40))) begin
      n_fail++;
      $display("FAIL midrst_reach got ticks %0d n %0d exp ticks 5 slot 40", m_ticks, m_n);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({bclk, lrclk, sdata, sample_tick} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_async got %b exp 0000", {bclk, lrclk, sdata, sample_tick});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3 * 128; c++) begin
      step();
      capture_bit();
      n_tests++;
      if ({bclk, lrclk, sdata, sample_tick} !== exp_outs()) begin
        n_fail++;
        $display("FAIL midrst n %0d got %b exp %b", m_n, {bclk, lrclk, sdata, sample_tick}, exp_outs());
      end
      if (at_slot(48)) begin
        exp_w = (m_ticks == 0) ? 16'h0000 : 16'h4000;
        n_tests++;
        if (cap_l !== exp_w || cap_r !== exp_w) begin
          n_fail++;
          $display("FAIL midrst_word frame %0d got L=%h R=%h exp %h", m_ticks, cap_l, cap_r, exp_w);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    cap_l = '0;
    cap_r = '0;
    @(negedge clk);
    test_reset();
    test_silence();
    test_square55();
    test_shrink();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
